// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: opcodes, decode enums and the ID/EX control bundle.
package riscv_pkg;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immsrc_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } resultsrc_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_t;

  typedef struct packed {
    logic       regwrite;
    resultsrc_t resultsrc;
    logic       memwrite;
    logic       jump;
    logic       branch;
    logic       alusrc;
    aluop_t     aluop;
  } ctrl_t;

  // A bubble carries no architectural side effects and drives every field to zero.
  localparam ctrl_t CTRL_BUBBLE = '{
    regwrite:  1'b0,
    resultsrc: RES_ALU,
    memwrite:  1'b0,
    jump:      1'b0,
    branch:    1'b0,
    alusrc:    1'b0,
    aluop:     ALU_ADD
  };

endpackage

// File: rtl/main_dec.sv
// Main opcode decoder: opcode to control bundle, immediate format and source-register usage.
module main_dec
  import riscv_pkg::*;
(
  input  logic [6:0] opcode_i,
  output ctrl_t      ctrl_o,
  output immsrc_t    immsrc_o,
  output logic       use_rs1_o,
  output logic       use_rs2_o,
  output logic       illegal_o
);

  // Unknown opcodes fall through with bubble control and the I immediate format.
  always_comb begin
    ctrl_o    = CTRL_BUBBLE;
    immsrc_o  = IMM_I;
    use_rs1_o = 1'b0;
    use_rs2_o = 1'b0;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_LW: begin
        ctrl_o.regwrite  = 1'b1;
        ctrl_o.resultsrc = RES_MEM;
        ctrl_o.alusrc    = 1'b1;
        ctrl_o.aluop     = ALU_ADD;
        immsrc_o         = IMM_I;
        use_rs1_o        = 1'b1;
      end
      OP_SW: begin
        ctrl_o.memwrite  = 1'b1;
        ctrl_o.alusrc    = 1'b1;
        ctrl_o.aluop     = ALU_ADD;
        immsrc_o         = IMM_S;
        use_rs1_o        = 1'b1;
        use_rs2_o        = 1'b1;
      end
      OP_R: begin
        ctrl_o.regwrite  = 1'b1;
        ctrl_o.resultsrc = RES_ALU;
        ctrl_o.aluop     = ALU_FUNCT;
        use_rs1_o        = 1'b1;
        use_rs2_o        = 1'b1;
      end
      OP_I: begin
        ctrl_o.regwrite  = 1'b1;
        ctrl_o.resultsrc = RES_ALU;
        ctrl_o.alusrc    = 1'b1;
        ctrl_o.aluop     = ALU_FUNCT;
        immsrc_o         = IMM_I;
        use_rs1_o        = 1'b1;
      end
      OP_B: begin
        ctrl_o.branch    = 1'b1;
        ctrl_o.aluop     = ALU_SUB;
        immsrc_o         = IMM_B;
        use_rs1_o        = 1'b1;
        use_rs2_o        = 1'b1;
      end
      OP_JAL: begin
        ctrl_o.regwrite  = 1'b1;
        ctrl_o.resultsrc = RES_PC4;
        ctrl_o.jump      = 1'b1;
        immsrc_o         = IMM_J;
      end
      OP_JALR: begin
        ctrl_o.regwrite  = 1'b1;
        ctrl_o.resultsrc = RES_PC4;
        ctrl_o.jump      = 1'b1;
        ctrl_o.alusrc    = 1'b1;
        ctrl_o.aluop     = ALU_ADD;
        immsrc_o         = IMM_I;
        use_rs1_o        = 1'b1;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_ctrl.sv
// Decode-stage controller: ID/EX control register, load-use stall and taken-branch flush.
// Define ILLEGAL_INSTR_EN to trap illegal opcodes into a sticky illegal_o flag.
module id_ex_ctrl
  import riscv_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       instr_d,
  input  logic              valid_d,
  input  logic              pcsrc_e,
  output logic [1:0]        immsrc_d,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              valid_e,
  output logic [REG_AW-1:0] rd_e,
  output logic [REG_AW-1:0] rs1_e,
  output logic [REG_AW-1:0] rs2_e,
  output logic              regwrite_e,
  output logic              memwrite_e,
  output logic              branch_e,
  output logic              jump_e,
  output logic              alusrc_e,
  output logic [1:0]        resultsrc_e,
  output logic [1:0]        aluop_e,
  output logic [2:0]        funct3_e,
  output logic              funct7b5_e
`ifdef ILLEGAL_INSTR_EN
  ,
  output logic              illegal_o,
  input  logic              illegal_clr
`endif
);

  ctrl_t             dec_ctrl;
  immsrc_t           dec_immsrc;
  logic              dec_use_rs1;
  logic              dec_use_rs2;
  logic              dec_illegal;

  logic [REG_AW-1:0] rs1_d;
  logic [REG_AW-1:0] rs2_d;
  logic [REG_AW-1:0] rdf_d;
  logic              lduse;
  logic              illegal_bubble;
  logic              bubble;

  ctrl_t             ex_ctrl_q, ex_ctrl_d;
  logic              ex_valid_q, ex_valid_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;
  logic [2:0]        ex_funct3_q, ex_funct3_d;
  logic              ex_f7b5_q, ex_f7b5_d;

  logic              unused_instr_bits;

  main_dec u_main_dec (
    .opcode_i  (instr_d[6:0]),
    .ctrl_o    (dec_ctrl),
    .immsrc_o  (dec_immsrc),
    .use_rs1_o (dec_use_rs1),
    .use_rs2_o (dec_use_rs2),
    .illegal_o (dec_illegal)
  );

  assign rs1_d    = instr_d[15 +: REG_AW];
  assign rs2_d    = instr_d[20 +: REG_AW];
  assign rdf_d    = instr_d[7 +: REG_AW];
  assign immsrc_d = dec_immsrc;

  assign unused_instr_bits = ^{instr_d[31], instr_d[29:25]};

  // A load in EX whose nonzero destination feeds a source actually read by D.
  assign lduse = valid_d & ex_valid_q & (ex_ctrl_q.resultsrc == RES_MEM) &
                 (ex_rd_q != '0) &
                 ((dec_use_rs1 & (rs1_d == ex_rd_q)) |
                  (dec_use_rs2 & (rs2_d == ex_rd_q)));

  assign flush_d = pcsrc_e;
  assign stall_f = lduse & ~pcsrc_e;
  assign stall_d = lduse & ~pcsrc_e;

`ifdef ILLEGAL_INSTR_EN
  logic illegal_q, illegal_d;
  logic illegal_set;

  assign illegal_bubble = valid_d & dec_illegal;
  assign illegal_set    = valid_d & dec_illegal & ~pcsrc_e & ~lduse;

  // Sticky flag; a new trap in the same cycle as a clear takes precedence.
  always_comb begin
    illegal_d = illegal_q;
    if (illegal_set) begin
      illegal_d = 1'b1;
    end else if (illegal_clr) begin
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal_o = illegal_q;
`else
  logic unused_illegal;

  assign illegal_bubble = 1'b0;
  assign unused_illegal = dec_illegal;
`endif

  assign bubble = pcsrc_e | lduse | ~valid_d | illegal_bubble;

  // Bubbles zero every field, including register numbers, so forwarding never matches stale data.
  always_comb begin
    ex_ctrl_d   = CTRL_BUBBLE;
    ex_valid_d  = 1'b0;
    ex_rd_d     = '0;
    ex_rs1_d    = '0;
    ex_rs2_d    = '0;
    ex_funct3_d = 3'b000;
    ex_f7b5_d   = 1'b0;
    if (!bubble) begin
      ex_ctrl_d   = dec_ctrl;
      ex_valid_d  = 1'b1;
      ex_rd_d     = rdf_d;
      ex_rs1_d    = rs1_d;
      ex_rs2_d    = rs2_d;
      ex_funct3_d = instr_d[14:12];
      ex_f7b5_d   = instr_d[30];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_ctrl_q   <= CTRL_BUBBLE;
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_funct3_q <= 3'b000;
      ex_f7b5_q   <= 1'b0;
    end else begin
      ex_ctrl_q   <= ex_ctrl_d;
      ex_valid_q  <= ex_valid_d;
      ex_rd_q     <= ex_rd_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      ex_funct3_q <= ex_funct3_d;
      ex_f7b5_q   <= ex_f7b5_d;
    end
  end

  assign valid_e     = ex_valid_q;
  assign rd_e        = ex_rd_q;
  assign rs1_e       = ex_rs1_q;
  assign rs2_e       = ex_rs2_q;
  assign regwrite_e  = ex_ctrl_q.regwrite;
  assign memwrite_e  = ex_ctrl_q.memwrite;
  assign branch_e    = ex_ctrl_q.branch;
  assign jump_e      = ex_ctrl_q.jump;
  assign alusrc_e    = ex_ctrl_q.alusrc;
  assign resultsrc_e = ex_ctrl_q.resultsrc;
  assign aluop_e     = ex_ctrl_q.aluop;
  assign funct3_e    = ex_funct3_q;
  assign funct7b5_e  = ex_f7b5_q;

endmodule

// File: tb/tb_id_ex_ctrl.sv
// Directed self-checking bench for id_ex_ctrl (default build or ILLEGAL_INSTR_EN).
module tb_id_ex_ctrl;

  logic        clk;
  logic        reset_n;
  logic [31:0] instr_d;
  logic        valid_d;
  logic        pcsrc_e;
  logic [1:0]  immsrc_d;
  logic        stall_f, stall_d, flush_d, valid_e;
  logic [4:0]  rd_e, rs1_e, rs2_e;
  logic        regwrite_e, memwrite_e, branch_e, jump_e, alusrc_e;
  logic [1:0]  resultsrc_e, aluop_e;
  logic [2:0]  funct3_e;
  logic        funct7b5_e;
`ifdef ILLEGAL_INSTR_EN
  logic        illegal_o;
  logic        illegal_clr;
`endif

  int testsRun;
  int testsFailed;

  id_ex_ctrl #(.REG_AW(5)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_d     (instr_d),
    .valid_d     (valid_d),
    .pcsrc_e     (pcsrc_e),
    .immsrc_d    (immsrc_d),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .valid_e     (valid_e),
    .rd_e        (rd_e),
    .rs1_e       (rs1_e),
    .rs2_e       (rs2_e),
    .regwrite_e  (regwrite_e),
    .memwrite_e  (memwrite_e),
    .branch_e    (branch_e),
    .jump_e      (jump_e),
    .alusrc_e    (alusrc_e),
    .resultsrc_e (resultsrc_e),
    .aluop_e     (aluop_e),
    .funct3_e    (funct3_e),
    .funct7b5_e  (funct7b5_e)
`ifdef ILLEGAL_INSTR_EN
    ,
    .illegal_o   (illegal_o),
    .illegal_clr (illegal_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive decode-stage inputs away from the rising edge and let combinational outputs settle.
  task automatic applyStimulus(input logic [31:0] instr, input logic valid, input logic pcsrc);
    @(negedge clk);
    instr_d = instr;
    valid_d = valid;
    pcsrc_e = pcsrc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] lwX5, addX6X5, lwX0, addX6X0, swI, beqI, jalI, addiI, jalrI, subI, luiI;

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    lwX5    = enc(7'h00, 5'd0, 5'd1, 3'b010, 5'd5, 7'b0000011);
    addX6X5 = enc(7'h00, 5'd2, 5'd5, 3'b000, 5'd6, 7'b0110011);
    lwX0    = enc(7'h00, 5'd0, 5'd1, 3'b010, 5'd0, 7'b0000011);
    addX6X0 = enc(7'h00, 5'd2, 5'd0, 3'b000, 5'd6, 7'b0110011);
    swI     = enc(7'h00, 5'd2, 5'd1, 3'b010, 5'd4, 7'b0100011);
    beqI    = enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011);
    jalI    = enc(7'h00, 5'd0, 5'd0, 3'b000, 5'd1, 7'b1101111);
    addiI   = enc(7'h00, 5'd5, 5'd1, 3'b000, 5'd3, 7'b0010011);
    jalrI   = enc(7'h00, 5'd0, 5'd2, 3'b000, 5'd1, 7'b1100111);
    subI    = enc(7'h20, 5'd2, 5'd1, 3'b000, 5'd7, 7'b0110011);
    luiI    = enc(7'h00, 5'd0, 5'd0, 3'b000, 5'd8, 7'b0110111);

    reset_n = 1'b1;
    instr_d = 32'h0;
    valid_d = 1'b0;
    pcsrc_e = 1'b0;
`ifdef ILLEGAL_INSTR_EN
    illegal_clr = 1'b0;
`endif
    #1 reset_n = 1'b0;
    #1;
    checkOutput("rst_valid_e", {31'b0, valid_e}, 32'd0);
    checkOutput("rst_regwrite_e", {31'b0, regwrite_e}, 32'd0);
    checkOutput("rst_rd_e", {27'b0, rd_e}, 32'd0);
    checkOutput("rst_stall_f", {31'b0, stall_f}, 32'd0);
    checkOutput("rst_flush_d", {31'b0, flush_d}, 32'd0);
`ifdef ILLEGAL_INSTR_EN
    checkOutput("rst_illegal_o", {31'b0, illegal_o}, 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    // Load-use: lw x5 then add x6,x5,x2
    applyStimulus(lwX5, 1'b1, 1'b0);
    checkOutput("lw_immsrc", {30'b0, immsrc_d}, 32'd0);
    tick();
    checkOutput("lw_valid_e", {31'b0, valid_e}, 32'd1);
    checkOutput("lw_rd_e", {27'b0, rd_e}, 32'd5);
    checkOutput("lw_rs1_e", {27'b0, rs1_e}, 32'd1);
    checkOutput("lw_resultsrc_e", {30'b0, resultsrc_e}, 32'd1);
    checkOutput("lw_regwrite_e", {31'b0, regwrite_e}, 32'd1);
    checkOutput("lw_alusrc_e", {31'b0, alusrc_e}, 32'd1);
    checkOutput("lw_funct3_e", {29'b0, funct3_e}, 32'd2);
    applyStimulus(addX6X5, 1'b1, 1'b0);
    checkOutput("lduse_stall_f", {31'b0, stall_f}, 32'd1);
    checkOutput("lduse_stall_d", {31'b0, stall_d}, 32'd1);
    checkOutput("lduse_flush_d", {31'b0, flush_d}, 32'd0);
    tick();
    checkOutput("bubble_valid_e", {31'b0, valid_e}, 32'd0);
    checkOutput("bubble_regwrite_e", {31'b0, regwrite_e}, 32'd0);
    checkOutput("bubble_rd_e", {27'b0, rd_e}, 32'd0);
    checkOutput("bubble_rs1_e", {27'b0, rs1_e}, 32'd0);
    applyStimulus(addX6X5, 1'b1, 1'b0);
    checkOutput("after_stall_f", {31'b0, stall_f}, 32'd0);
    tick();
    checkOutput("add_valid_e", {31'b0, valid_e}, 32'd1);
    checkOutput("add_rs1_e", {27'b0, rs1_e}, 32'd5);
    checkOutput("add_rs2_e", {27'b0, rs2_e}, 32'd2);
    checkOutput("add_rd_e", {27'b0, rd_e}, 32'd6);
    checkOutput("add_aluop_e", {30'b0, aluop_e}, 32'd2);

    // Load into x0 never stalls
    applyStimulus(lwX0, 1'b1, 1'b0);
    tick();
    checkOutput("lwx0_resultsrc_e", {30'b0, resultsrc_e}, 32'd1);
    applyStimulus(addX6X0, 1'b1, 1'b0);
    checkOutput("x0_no_stall", {31'b0, stall_f}, 32'd0);
    tick();
    checkOutput("x0_add_valid_e", {31'b0, valid_e}, 32'd1);

    // Redirect while load-use pending in D
    applyStimulus(lwX5, 1'b1, 1'b0);
    tick();
    applyStimulus(addX6X5, 1'b1, 1'b1);
    checkOutput("flush_flush_d", {31'b0, flush_d}, 32'd1);
    checkOutput("flush_stall_f", {31'b0, stall_f}, 32'd0);
    checkOutput("flush_stall_d", {31'b0, stall_d}, 32'd0);
    tick();
    checkOutput("flush_valid_e", {31'b0, valid_e}, 32'd0);
    checkOutput("flush_regwrite_e", {31'b0, regwrite_e}, 32'd0);
    checkOutput("flush_rd_e", {27'b0, rd_e}, 32'd0);

    // Invalid D slot bubbles without stalling
    applyStimulus(lwX5, 1'b1, 1'b0);
    tick();
    applyStimulus(addX6X5, 1'b0, 1'b0);
    checkOutput("nvalid_stall_f", {31'b0, stall_f}, 32'd0);
    tick();
    checkOutput("nvalid_valid_e", {31'b0, valid_e}, 32'd0);

    // Immediate format sweep and per-class control
    applyStimulus(swI, 1'b1, 1'b0);
    checkOutput("sw_immsrc", {30'b0, immsrc_d}, 32'd1);
    tick();
    checkOutput("sw_memwrite_e", {31'b0, memwrite_e}, 32'd1);
    checkOutput("sw_regwrite_e", {31'b0, regwrite_e}, 32'd0);
    applyStimulus(beqI, 1'b1, 1'b0);
    checkOutput("beq_immsrc", {30'b0, immsrc_d}, 32'd2);
    tick();
    checkOutput("beq_branch_e", {31'b0, branch_e}, 32'd1);
    checkOutput("beq_aluop_e", {30'b0, aluop_e}, 32'd1);
    applyStimulus(jalI, 1'b1, 1'b0);
    checkOutput("jal_immsrc", {30'b0, immsrc_d}, 32'd3);
    tick();
    checkOutput("jal_jump_e", {31'b0, jump_e}, 32'd1);
    checkOutput("jal_resultsrc_e", {30'b0, resultsrc_e}, 32'd2);
    checkOutput("jal_regwrite_e", {31'b0, regwrite_e}, 32'd1);
    checkOutput("jal_rd_e", {27'b0, rd_e}, 32'd1);
    applyStimulus(addiI, 1'b1, 1'b0);
    checkOutput("addi_immsrc", {30'b0, immsrc_d}, 32'd0);
    tick();
    checkOutput("addi_aluop_e", {30'b0, aluop_e}, 32'd2);
    checkOutput("addi_alusrc_e", {31'b0, alusrc_e}, 32'd1);
    applyStimulus(jalrI, 1'b1, 1'b0);
    checkOutput("jalr_immsrc", {30'b0, immsrc_d}, 32'd0);
    tick();
    checkOutput("jalr_jump_e", {31'b0, jump_e}, 32'd1);
    checkOutput("jalr_resultsrc_e", {30'b0, resultsrc_e}, 32'd2);
    checkOutput("jalr_alusrc_e", {31'b0, alusrc_e}, 32'd1);
    applyStimulus(subI, 1'b1, 1'b0);
    tick();
    checkOutput("sub_funct7b5_e", {31'b0, funct7b5_e}, 32'd1);
    checkOutput("sub_funct3_e", {29'b0, funct3_e}, 32'd0);
    applyStimulus(beqI, 1'b0, 1'b0);
    checkOutput("nvalid_immsrc", {30'b0, immsrc_d}, 32'd2);
    tick();

    // Illegal opcode (lui)
    applyStimulus(luiI, 1'b1, 1'b0);
    checkOutput("lui_immsrc", {30'b0, immsrc_d}, 32'd0);
    tick();
`ifdef ILLEGAL_INSTR_EN
    checkOutput("lui_illegal_o", {31'b0, illegal_o}, 32'd1);
    checkOutput("lui_valid_e", {31'b0, valid_e}, 32'd0);
    applyStimulus(addiI, 1'b1, 1'b0);
    tick();
    checkOutput("illegal_sticky", {31'b0, illegal_o}, 32'd1);
    illegal_clr = 1'b1;
    applyStimulus(luiI, 1'b1, 1'b0);
    tick();
    checkOutput("illegal_set_wins", {31'b0, illegal_o}, 32'd1);
    applyStimulus(addiI, 1'b1, 1'b0);
    tick();
    checkOutput("illegal_cleared", {31'b0, illegal_o}, 32'd0);
    illegal_clr = 1'b0;
`else
    checkOutput("lui_valid_e", {31'b0, valid_e}, 32'd1);
    checkOutput("lui_regwrite_e", {31'b0, regwrite_e}, 32'd0);
    checkOutput("lui_memwrite_e", {31'b0, memwrite_e}, 32'd0);
    checkOutput("lui_resultsrc_e", {30'b0, resultsrc_e}, 32'd0);
    checkOutput("lui_aluop_e", {30'b0, aluop_e}, 32'd0);
    checkOutput("lui_alusrc_e", {31'b0, alusrc_e}, 32'd0);
`endif

    // Asynchronous reset between clock edges
    applyStimulus(addiI, 1'b1, 1'b0);
    tick();
    checkOutput("pre_rst_valid_e", {31'b0, valid_e}, 32'd1);
    checkOutput("pre_rst_rd_e", {27'b0, rd_e}, 32'd3);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_rst_valid_e", {31'b0, valid_e}, 32'd0);
    checkOutput("async_rst_rd_e", {27'b0, rd_e}, 32'd0);
    checkOutput("async_rst_regwrite_e", {31'b0, regwrite_e}, 32'd0);
    checkOutput("async_rst_aluop_e", {30'b0, aluop_e}, 32'd0);
    checkOutput("async_rst_alusrc_e", {31'b0, alusrc_e}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
